// File: rtl/insn_encode_writer_if.sv
// rtl/insn_encode_writer_if.sv - field-tuple input stream and instruction-memory write port bundle
// Purpose: groups the field-tuple handshake and the memory write port of insn_encode_writer.
// Ports (signals):
//   tuple side : in_valid, in_ready, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm
//   memory side: mem_we, mem_addr, mem_wdata, mem_ready
//   status     : wr_count, err_fmt
// Modports: master = field source / memory environment, slave = the encoder-writer.
interface insn_encode_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] wr_count;
  logic        err_fmt;

  modport master (
    output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, wr_count, err_fmt
  );

  modport slave (
    input  in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, wr_count, err_fmt
  );
endinterface

// File: rtl/insn_encode_writer.sv
// rtl/insn_encode_writer.sv - RV32I field encoder with FIFO and sequential memory writer
// Purpose: assembles RV32I instruction words from field tuples, buffers them in a
// DEPTH-entry FIFO and writes them to consecutive word addresses from BASE_ADDR.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   clr   - synchronous flush of FIFO, address and write counter
//   bus   - insn_encode_writer_if.slave (tuple input, memory write port, status)
module insn_encode_writer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  insn_encode_writer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] fifo_mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic        err_q;

  logic [31:0] word;
  logic        fmt_ok;
  logic        full, empty, accept, push, pop;

  // Word assembly; bits [6:0] are common to every format.
  always_comb begin
    word   = 32'h0;
    fmt_ok = 1'b1;
    case (bus.fmt)
      3'd0: word[31:7] = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd};
      3'd1: word[31:7] = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd};
      3'd2: word[31:7] = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0]};
      3'd3: word[31:7] = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                          bus.imm[4:1], bus.imm[11]};
      3'd4: word[31:7] = {bus.imm[31:12], bus.rd};
      3'd5: word[31:7] = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd};
      default: fmt_ok = 1'b0;
    endcase
    word[6:0] = {bus.opcode, 2'b11};
  end

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.in_ready = !full && !clr;
  assign accept = bus.in_valid && !full && !clr;
  // Invalid formats are consumed but never stored.
  assign push   = accept && fmt_ok;
  assign pop    = !empty && bus.mem_ready && !clr;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= 16'h0;
      err_q   <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      addr_q  <= BASE_ADDR;
      count_q <= 16'h0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && !fmt_ok;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        addr_q  <= addr_q + 32'd4;
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.mem_we    = !empty;
  // Head storage is not reset, so present zero whenever nothing is queued.
  assign bus.mem_wdata = empty ? 32'h0 : fifo_mem[rd_ptr[AW-1:0]];
  assign bus.mem_addr  = addr_q;
  assign bus.wr_count  = count_q;
  assign bus.err_fmt   = err_q;
endmodule

// File: tb/tb_insn_encode_writer.sv
// tb/tb_insn_encode_writer.sv - directed self-checking bench for insn_encode_writer
module tb_insn_encode_writer;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  insn_encode_writer_if bus ();

  insn_encode_writer #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tup(input logic [2:0] f, input logic [4:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [31:0] im);
    bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    bus.in_valid = 1'b0; bus.mem_ready = 1'b0;
    tup(3'd0, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    tick(); tick();
    chk("rst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_cnt",   {16'd0, bus.wr_count}, 32'd0);
    chk("rst_err",   {31'd0, bus.err_fmt}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // addi x1, x0, 5
    bus.mem_ready = 1'b1;
    tup(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("addi_we",    {31'd0, bus.mem_we}, 32'd1);
    chk("addi_addr",  bus.mem_addr, 32'h0);
    chk("addi_wdata", bus.mem_wdata, 32'h00500093);
    chk("addi_cnt0",  {16'd0, bus.wr_count}, 32'd0);
    tick();
    chk("addi_cnt1",  {16'd0, bus.wr_count}, 32'd1);
    chk("addi_idle",  {31'd0, bus.mem_we}, 32'd0);
    chk("addi_addr4", bus.mem_addr, 32'h4);

    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr1_addr", bus.mem_addr, 32'h0);
    chk("clr1_cnt",  {16'd0, bus.wr_count}, 32'd0);

    // back-to-back R add, S sw, U lui
    tup(3'd0, 5'b01100, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    bus.in_valid = 1'b1;
    tick();
    chk("add_wdata", bus.mem_wdata, 32'h002081B3);
    chk("add_addr",  bus.mem_addr, 32'h0);
    tup(3'd2, 5'b01000, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    chk("sw_wdata", bus.mem_wdata, 32'h0020A423);
    chk("sw_addr",  bus.mem_addr, 32'h4);
    tup(3'd4, 5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    bus.in_valid = 1'b0;
    chk("lui_wdata", bus.mem_wdata, 32'h123452B7);
    chk("lui_addr",  bus.mem_addr, 32'h8);
    tick();
    chk("b2b_idle", {31'd0, bus.mem_we}, 32'd0);
    chk("b2b_cnt",  {16'd0, bus.wr_count}, 32'd3);

    // beq x0, x0, -4 then jal x1, 8
    tup(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    bus.in_valid = 1'b1;
    tick();
    chk("beq_wdata", bus.mem_wdata, 32'hFE000EE3);
    chk("beq_addr",  bus.mem_addr, 32'hC);
    tup(3'd5, 5'b11011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
    tick();
    bus.in_valid = 1'b0;
    chk("jal_wdata", bus.mem_wdata, 32'h008000EF);
    chk("jal_addr",  bus.mem_addr, 32'h10);
    tick();
    chk("bj_cnt", {16'd0, bus.wr_count}, 32'd5);

    // fill FIFO with the memory stalled
    clr = 1'b1; tick(); clr = 1'b0;
    bus.mem_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tup(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      tick();
      chk("fill_addr",  bus.mem_addr, 32'h0);
      chk("fill_wdata", bus.mem_wdata, 32'h00100093);
    end
    tup(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd9);
    chk("full_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("full_ready2", {31'd0, bus.in_ready}, 32'd0);
    chk("stall_addr",  bus.mem_addr, 32'h0);
    chk("stall_wdata", bus.mem_wdata, 32'h00100093);
    chk("stall_cnt",   {16'd0, bus.wr_count}, 32'd0);
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_we",    {31'd0, bus.mem_we}, 32'd1);
      chk("drain_addr",  bus.mem_addr, 32'(4 * k));
      chk("drain_wdata", bus.mem_wdata, 32'((k + 1) << 20) | 32'h93);
      tick();
    end
    chk("drain_idle",  {31'd0, bus.mem_we}, 32'd0);
    chk("drain_cnt",   {16'd0, bus.wr_count}, 32'd4);
    chk("drain_ready", {31'd0, bus.in_ready}, 32'd1);

    // invalid format
    tup(3'd7, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("bad_err",  {31'd0, bus.err_fmt}, 32'd1);
    chk("bad_we",   {31'd0, bus.mem_we}, 32'd0);
    tick();
    chk("bad_err0", {31'd0, bus.err_fmt}, 32'd0);
    chk("bad_cnt",  {16'd0, bus.wr_count}, 32'd4);

    // clr with two words stalled
    bus.mem_ready = 1'b0;
    tup(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.in_valid = 1'b1;
    tick(); tick();
    bus.in_valid = 1'b0;
    chk("pclr_we",   {31'd0, bus.mem_we}, 32'd1);
    chk("pclr_addr", bus.mem_addr, 32'h10);
    clr = 1'b1;
    #1;
    chk("clr_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    clr = 1'b0;
    #1;
    chk("clr_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("clr_addr",  bus.mem_addr, 32'h0);
    chk("clr_cnt",   {16'd0, bus.wr_count}, 32'd0);
    chk("clr_ready1", {31'd0, bus.in_ready}, 32'd1);

    // asynchronous reset mid-stream
    bus.mem_ready = 1'b1;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    tick();
    chk("prst_cnt", {16'd0, bus.wr_count}, 32'd1);
    bus.mem_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    chk("prst_we", {31'd0, bus.mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("arst_addr",  bus.mem_addr, 32'h0);
    chk("arst_wdata", bus.mem_wdata, 32'h0);
    chk("arst_cnt",   {16'd0, bus.wr_count}, 32'd0);
    chk("arst_err",   {31'd0, bus.err_fmt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/insn_encode_writer.md
Name: insn_encode_writer

Overview:
- Inverse of the instruction field decoder: takes RV32I instruction fields plus a format selector and assembles the 32-bit instruction word.
- Buffers encoded words in a small FIFO.
- Writes the words sequentially into instruction memory through a stallable write port.
- Used by the test/boot loader path to fill program memory from a field-level stream.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- BASE_ADDR, 32'h0000_0000, byte address of the first write after reset or clr.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush: empties the FIFO, reloads the address to BASE_ADDR, clears wr_count.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  block can accept a tuple.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 invalid.
- opcode  in  5  instruction bits [6:2].
- funct3  in  3  bits [14:12].
- funct7  in  7  bits [31:25], R format only.
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- imm  in  32  immediate, format-specific bits used.
- mem_we  out  1  write request.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  encoded word.
- mem_ready  in  1  memory accepts the write this cycle.
- wr_count  out  16  completed writes since reset or clr; wraps.
- err_fmt  out  1  one-cycle pulse, invalid fmt accepted.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, wr_count=0, err_fmt=0. in_ready=1 once reset is released.
- Encoding (combinational, then pushed into the FIFO). Bits [1:0] are always 2'b11, and [6:2]=opcode in every format.
  - R: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7].
  - I: imm[11:0]→[31:20], rs1, funct3, rd.
  - S: imm[11:5]→[31:25], rs2, rs1, funct3, imm[4:0]→[11:7].
  - B: imm[12]→31, imm[10:5]→[30:25], rs2, rs1, funct3, imm[4:1]→[11:8], imm[11]→7. imm[0] ignored.
  - U: imm[31:12]→[31:12], rd.
  - J: imm[20]→31, imm[10:1]→[30:21], imm[11]→20, imm[19:12]→[19:12], rd. imm[0] ignored.
  - Unused input fields are ignored. No range checks on any field.
- Input handshake:
  - A tuple is accepted on a cycle with in_valid && in_ready.
  - in_ready = !full && !clr. A pop in the same cycle does not free space for that cycle.
- Invalid fmt (6/7): tuple is accepted but not pushed; err_fmt=1 on the next cycle only.
- FIFO: circular buffer of DEPTH words with pointers that carry an extra wrap bit. Simultaneous push and pop is allowed when non-full and non-empty; occupancy is unchanged.
- Write port:
  - mem_we=1 whenever the FIFO is non-empty. mem_wdata is the FIFO head; mem_addr is the current address register.
  - A write completes on mem_we && mem_ready: pop the head, mem_addr += 4 (wraps modulo 2^32), wr_count += 1.
  - While mem_ready=0, mem_we, mem_addr and mem_wdata hold stable.
- Latency: a tuple accepted at edge N into an empty FIFO gives mem_we=1 with its word from cycle N+1. Sustained throughput is one word per cycle with mem_ready=1.
- clr: takes priority over push and pop that cycle. Any in-flight write is abandoned, with no completion counted. Next cycle: mem_we=0, mem_addr=BASE_ADDR.
- Reset mid-transfer: immediate return to reset values. Buffered words are lost.

Test Plan:
- Reset, then push I addi (opcode=5'b00100, rd=1, rs1=0, funct3=0, imm=5), mem_ready=1 → next cycle mem_we=1, mem_addr=0, mem_wdata=32'h00500093; wr_count=1 after the write.
- Back-to-back R add (rd=3, rs1=1, rs2=2, opcode=5'b01100), S sw (rs1=1, rs2=2, funct3=2, imm=8, opcode=5'b01000), U lui (rd=5, imm=32'h12345000, opcode=5'b01101) → 002081B3@0, 0020A423@4, 123452B7@8 on consecutive cycles.
- B beq (rs1=rs2=0, imm=-4, opcode=5'b11000) → FE000EE3. J jal (rd=1, imm=8, opcode=5'b11011) → 008000EF.
- Hold mem_ready=0 and push 4 tuples with DEPTH=4 → in_ready=0 and addr/wdata stable. Release → 4 writes at 0, 4, 8, C, then in_ready returns to 1.
- Push with fmt=7 → no mem_we, err_fmt pulses exactly one cycle, wr_count unchanged.
- Fill 2 words with mem_ready=0, assert clr → FIFO empty, mem_addr=BASE_ADDR, wr_count=0. Assert rst_n=0 mid-stream → all outputs at reset values asynchronously.
